// File: rtl/dc_fifo_pkg.sv
// rtl/dc_fifo_pkg.sv - constants shared by the source and destination halves of the token-ring FIFO
package dc_fifo_pkg;

  localparam int DEFAULT_BUFFER_WIDTH = 8;

  // Both domains start with bit 0 set; sliced down to the actual buffer width by users.
  localparam int MAX_TOKEN_WIDTH = 64;
  localparam logic [MAX_TOKEN_WIDTH-1:0] TOKEN_RESET = 64'h1;

endpackage

// File: rtl/dc_synchronizer.sv
// rtl/dc_synchronizer.sv - two-flop synchronizer for a one-hot pointer crossing clock domains
module dc_synchronizer #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      meta <= RESET_VALUE;
      q_o  <= RESET_VALUE;
    end else begin
      meta <= d_i;
      q_o  <= meta;
    end
  end

endmodule

// File: rtl/dc_token_ring_fifo_src.sv
// rtl/dc_token_ring_fifo_src.sv - source half of a dual-clock FIFO using a rotating one-hot write token
module dc_token_ring_fifo_src
  import dc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int BUFFER_WIDTH = DEFAULT_BUFFER_WIDTH
) (
  input  logic                               clk_i,
  input  logic                               rstn_i,
  input  logic [DATA_WIDTH-1:0]              data_i,
  input  logic                               valid_i,
  output logic                               ready_o,
  output logic [BUFFER_WIDTH-1:0]            write_token_o,
  input  logic [BUFFER_WIDTH-1:0]            read_pointer_i,
  output logic [BUFFER_WIDTH*DATA_WIDTH-1:0] data_async_o
);

  localparam logic [BUFFER_WIDTH-1:0] TOKEN_INIT = TOKEN_RESET[BUFFER_WIDTH-1:0];

  logic [BUFFER_WIDTH-1:0] wt;
  logic [BUFFER_WIDTH-1:0] nt;
  logic [BUFFER_WIDTH-1:0] rp_sync;
  logic                    push;

  dc_synchronizer #(
    .WIDTH       (BUFFER_WIDTH),
    .RESET_VALUE (TOKEN_INIT)
  ) u_rp_sync (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .d_i    (read_pointer_i),
    .q_o    (rp_sync)
  );

  assign nt = {wt[BUFFER_WIDTH-2:0], wt[BUFFER_WIDTH-1]};

  // A pointer caught mid-transition (zero or two bits set) must never look writable.
  assign ready_o       = (rp_sync != '0) && ((rp_sync & nt) == '0);
  assign push          = valid_i && ready_o;
  assign write_token_o = wt;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wt <= TOKEN_INIT;
    end else if (push) begin
      wt <= nt;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      data_async_o <= '0;
    end else if (push) begin
      for (int i = 0; i < BUFFER_WIDTH; i++) begin
        if (wt[i]) begin
          data_async_o[i*DATA_WIDTH +: DATA_WIDTH] <= data_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_dc_token_ring_fifo_src.sv
// tb/tb_dc_token_ring_fifo_src.sv - scoreboard bench for the token-ring FIFO source half
module tb_dc_token_ring_fifo_src;

  localparam int DW = 32;
  localparam int BW = 8;

  logic             clk = 1'b0;
  logic             rstn;
  logic             valid;
  logic [DW-1:0]    data;
  logic [BW-1:0]    rp;
  logic             ready;
  logic [BW-1:0]    wt_o;
  logic [BW*DW-1:0] dout;

  int n_checks = 0;
  int n_fail   = 0;

  dc_token_ring_fifo_src #(
    .DATA_WIDTH   (DW),
    .BUFFER_WIDTH (BW)
  ) dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .data_i         (data),
    .valid_i        (valid),
    .ready_o        (ready),
    .write_token_o  (wt_o),
    .read_pointer_i (rp),
    .data_async_o   (dout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [BW*DW-1:0] act, input logic [BW*DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] onehot(input int i);
    logic [BW-1:0] one;
    one = 1;
    return one << i;
  endfunction

  function automatic logic [DW-1:0] slot(input int i);
    return dout[i*DW +: DW];
  endfunction

  // Reference model: integer write position, array of slots, pointer seen two edges late.
  typedef struct {
    int            idx;
    logic [DW-1:0] d;
  } exp_t;

  exp_t          exp_q[$];
  int            widx = 0;
  logic [DW-1:0] mem [BW];
  logic [BW-1:0] rp_d1 = 1;
  logic [BW-1:0] rp_d2 = 1;

  function automatic logic model_ready();
    int nidx;
    nidx = (widx + 1) % BW;
    return (rp_d2 != 0) && (rp_d2[nidx] == 1'b0);
  endfunction

  function automatic logic [BW*DW-1:0] model_flat();
    logic [BW*DW-1:0] f;
    f = '0;
    for (int i = 0; i < BW; i++) f[i*DW +: DW] = mem[i];
    return f;
  endfunction

  initial begin
    for (int i = 0; i < BW; i++) mem[i] = '0;
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        widx  = 0;
        rp_d1 = 1;
        rp_d2 = 1;
        for (int i = 0; i < BW; i++) mem[i] = '0;
        exp_q.delete();
      end else begin
        if (valid && model_ready()) begin
          mem[widx] = data;
          exp_q.push_back('{widx, data});
          widx = (widx + 1) % BW;
        end
        rp_d2 = rp_d1;
        rp_d1 = rp;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn === 1'b1) begin
        check("ready", ready, model_ready());
        check("token", wt_o, onehot(widx));
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("written_slot", slot(e.idx), e.d);
        end
        check("all_slots", dout, model_flat());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn  = 1'b0;
    valid = 1'b0;
    rp    = 8'h01;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  initial begin
    int   acc;
    logic r;
    logic [BW-1:0] t;

    rstn  = 1'b0;
    valid = 1'b0;
    data  = '0;
    rp    = 8'h01;
    tick();
    tick();
    rstn = 1'b1;
    check("rst_token", wt_o, 8'h01);
    check("rst_ready", ready, 1'b1);
    check("rst_slots", dout, '0);
    tick();

    // Fill until full with the reader parked at slot 0.
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      data  = 32'hA0 + 32'(acc);
      valid = 1'b1;
      r     = ready;
      tick();
      if (r) acc++;
    end
    valid = 1'b0;
    check("burst_count", acc, 7);
    check("full_ready", ready, 1'b0);
    check("full_token", wt_o, 8'h80);
    for (int i = 0; i < 7; i++) check("burst_slot", slot(i), 32'hA0 + 32'(i));
    check("slot7_untouched", slot(7), 32'h0);

    // Reader advances; ready appears after the two synchronizer stages.
    rp = 8'h02;
    tick();
    check("rp_lat1_ready", ready, 1'b0);
    tick();
    check("rp_lat2_ready", ready, 1'b1);
    data  = 32'hA7;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    check("wrap_token", wt_o, 8'h01);
    check("wrap_slot7", slot(7), 32'hA7);
    check("wrap_full", ready, 1'b0);

    do_reset();
    tick();
    data  = 32'hB0;
    valid = 1'b1;
    tick();
    check("toggle_tok1", wt_o, 8'h02);
    valid = 1'b0;
    tick();
    check("toggle_tok2", wt_o, 8'h02);
    data  = 32'hB1;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    check("toggle_tok3", wt_o, 8'h04);
    check("toggle_slot0", slot(0), 32'hB0);
    check("toggle_slot1", slot(1), 32'hB1);
    for (int i = 2; i < BW; i++) check("toggle_other", slot(i), 32'h0);

    // Transient pointers (all-zero, two bits set) must read as full.
    do_reset();
    tick();
    rp = 8'h00;
    tick();
    check("zero_lat1_ready", ready, 1'b1);
    tick();
    check("zero_lat2_ready", ready, 1'b0);
    valid = 1'b1;
    data  = 32'hDEAD;
    tick();
    check("zero_token", wt_o, 8'h01);
    rp = 8'h06;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("two_bit_ready", ready, 1'b0);
    end
    check("two_bit_token", wt_o, 8'h01);
    valid = 1'b0;
    rp    = 8'h01;
    tick();
    tick();
    check("recover_ready", ready, 1'b1);

    // Asynchronous reset in the middle of a burst.
    do_reset();
    tick();
    valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      data = 32'hC0 + 32'(k);
      tick();
    end
    check("pre_reset_token", wt_o, 8'h08);
    #2;
    rstn = 1'b0;
    #1;
    check("async_rst_token", wt_o, 8'h01);
    check("async_rst_slots", dout, '0);
    valid = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    check("post_rst_ready", ready, 1'b1);
    tick();

    for (int c = 0; c < 500; c++) begin
      valid = ($urandom_range(3) != 0);
      data  = $urandom;
      if ($urandom_range(3) == 0) begin
        case ($urandom_range(9))
          0: rp = '0;
          1: begin
            t  = onehot($urandom_range(BW - 1));
            rp = t | {t[BW-2:0], t[BW-1]};
          end
          default: rp = onehot($urandom_range(BW - 1));
        endcase
      end
      tick();
    end
    valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
